// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: default datapath widths and the instruction-queue
// entry layout, which the decoder reuses when it unpacks queue output.
package cpu_defs_pkg;

    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    // Field order matches the {pred_taken, pc, inst} packing used by the queue storage.
    typedef struct packed {
        logic                  pred_taken;
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/iq_ram.sv
// Instruction-queue storage: DEPTH x W register array with one synchronous write port
// and one asynchronous (combinational) read port.
module iq_ram #(
    parameter  int DEPTH = 32,
    parameter  int W     = 65,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; occupancy lives in the pointers/count, so stale data is never observed as valid.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue_param.sv
// Parametrised instruction queue between fetch and decode: circular buffer with
// per-entry PC/prediction tags, valid/ready handshakes, flush, count and almost_full.
module inst_queue_param
    import cpu_defs_pkg::*;
#(
    parameter  int DEPTH    = 32,
    parameter  int INST_W   = INST_W_DEF,
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int AFULL_TH = DEPTH - 4,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              in_pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_taken,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INST_W + ADDR_W + 1;

    initial begin
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
            $error("inst_queue_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
        if (AFULL_TH < 1 || AFULL_TH > DEPTH)
            $error("inst_queue_param: AFULL_TH=%0d outside 1..%0d", AFULL_TH, DEPTH);
    end

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] rd_data;

    // Full/empty come from the registered count, since head == tail is ambiguous.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign almost_full = (count >= CNT_W'(AFULL_TH));

    assign push = in_valid  && in_ready  && rdy_in && !flush_in;
    assign pop  = out_valid && out_ready && rdy_in && !flush_in;

    iq_ram #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ram (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (tail),
        .wdata  ({in_pred_taken, in_pc, in_inst}),
        .raddr  (head),
        .rdata  (rd_data)
    );

    assign {out_pred_taken, out_pc, out_inst} = rd_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
